// File: rtl/id_ex_stage_pkg.sv
// Shared widths and NOP control encodings for the ID/EX stage and decode.
package id_ex_stage_pkg;
   localparam int XLEN_DEF    = 32;
   localparam int RWIDTH_DEF  = 5;
   localparam int ALUOP_W_DEF = 5;

   localparam logic [ALUOP_W_DEF-1:0] ALUOP_NOP     = '0;
   localparam logic [1:0]             WDSEL_DEFAULT = 2'd0;

   function automatic logic sat_inc_en(input logic [31:0] cnt);
      return cnt != 32'hFFFF_FFFF;
   endfunction
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose rd is read by the instruction in ID.
module load_use_detect #(
   parameter int RWIDTH = 5
) (
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [RWIDTH-1:0] ex_rd,
   input  logic              id_valid,
   input  logic              id_use_rs1,
   input  logic [RWIDTH-1:0] id_rs1,
   input  logic              id_use_rs2,
   input  logic [RWIDTH-1:0] id_rs2,
   output logic              hz
);
   logic match_rs1, match_rs2;

   assign match_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
   assign match_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
   // x0 is never a real producer, so rd==0 must not stall
   assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && (match_rs1 || match_rs2) && id_valid;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and freeze.
// Optional macro ID_EX_PERF_CNT_EN adds saturating bubble_cnt / flush_cnt outputs.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int RWIDTH  = RWIDTH_DEF,
   parameter int ALUOP_W = ALUOP_W_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               freeze,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [RWIDTH-1:0]  id_rs1,
   input  logic [RWIDTH-1:0]  id_rs2,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [RWIDTH-1:0]  id_rd,
   input  logic [XLEN-1:0]    id_rd1,
   input  logic [XLEN-1:0]    id_rd2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic               id_RegWrite,
   input  logic               id_MemRead,
   input  logic               id_MemWrite,
   input  logic [ALUOP_W-1:0] id_ALUOp,
   input  logic [1:0]         id_WDSel,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [RWIDTH-1:0]  ex_rs1,
   output logic [RWIDTH-1:0]  ex_rs2,
   output logic               ex_use_rs1,
   output logic               ex_use_rs2,
   output logic [RWIDTH-1:0]  ex_rd,
   output logic [XLEN-1:0]    ex_rd1,
   output logic [XLEN-1:0]    ex_rd2,
   output logic [XLEN-1:0]    ex_imm,
   output logic               ex_RegWrite,
   output logic               ex_MemRead,
   output logic               ex_MemWrite,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic [1:0]         ex_WDSel,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]        bubble_cnt,
   output logic [31:0]        flush_cnt,
`endif
   output logic               pc_hold
);
   logic               hz;
   logic               valid_q, valid_d;
   logic [XLEN-1:0]    pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [RWIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic               use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
   logic               reg_write_q, reg_write_d, mem_read_q, mem_read_d;
   logic               mem_write_q, mem_write_d;
   logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
   logic [1:0]         wd_sel_q, wd_sel_d;

   load_use_detect #(.RWIDTH(RWIDTH)) u_lud (
      .ex_valid    (valid_q),
      .ex_mem_read (mem_read_q),
      .ex_rd       (rd_q),
      .id_valid    (id_valid),
      .id_use_rs1  (id_use_rs1),
      .id_rs1      (id_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rs2      (id_rs2),
      .hz          (hz)
   );

   // A flush redirects fetch, so it must not also hold the PC
   assign pc_hold = freeze || (hz && !flush);

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      use_rs1_d   = use_rs1_q;
      use_rs2_d   = use_rs2_q;
      rd_d        = rd_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      imm_d       = imm_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      alu_op_d    = alu_op_q;
      wd_sel_d    = wd_sel_q;
      if (!freeze) begin
         if (flush || hz || !id_valid) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            use_rs1_d   = 1'b0;
            use_rs2_d   = 1'b0;
            rd_d        = '0;
            rd1_d       = '0;
            rd2_d       = '0;
            imm_d       = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            alu_op_d    = ALUOP_W'(ALUOP_NOP);
            wd_sel_d    = WDSEL_DEFAULT;
         end else begin
            valid_d     = 1'b1;
            pc_d        = id_pc;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            use_rs1_d   = id_use_rs1;
            use_rs2_d   = id_use_rs2;
            rd_d        = id_rd;
            rd1_d       = id_rd1;
            rd2_d       = id_rd2;
            imm_d       = id_imm;
            reg_write_d = id_RegWrite;
            mem_read_d  = id_MemRead;
            mem_write_d = id_MemWrite;
            alu_op_d    = id_ALUOp;
            wd_sel_d    = id_WDSel;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         use_rs1_q   <= 1'b0;
         use_rs2_q   <= 1'b0;
         rd_q        <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         alu_op_q    <= '0;
         wd_sel_q    <= '0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         use_rs1_q   <= use_rs1_d;
         use_rs2_q   <= use_rs2_d;
         rd_q        <= rd_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         alu_op_q    <= alu_op_d;
         wd_sel_q    <= wd_sel_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_use_rs1  = use_rs1_q;
   assign ex_use_rs2  = use_rs2_q;
   assign ex_rd       = rd_q;
   assign ex_rd1      = rd1_q;
   assign ex_rd2      = rd2_q;
   assign ex_imm      = imm_q;
   assign ex_RegWrite = reg_write_q;
   assign ex_MemRead  = mem_read_q;
   assign ex_MemWrite = mem_write_q;
   assign ex_ALUOp    = alu_op_q;
   assign ex_WDSel    = wd_sel_q;

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (!freeze && flush && sat_inc_en(flush_cnt_q))
         flush_cnt_d = flush_cnt_q + 32'd1;
      if (!freeze && !flush && hz && sat_inc_en(bubble_cnt_q))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`endif
endmodule
